// File: rtl/memoria_instrucoes_carga.sv
// Row/column instruction memory with a post-reset clear-to-NOP sweep, a
// valid/ready program-load port and a registered read port with error flags.
module memoria_instrucoes_carga #(
   parameter int                 LARGURA     = 32,
   parameter int                 LINHAS      = 40,
   parameter int                 COLUNAS     = 40,
   parameter int                 END_W       = 11,
   parameter logic [LARGURA-1:0] PALAVRA_NOP = 32'hD000_0000
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [END_W-1:0]   end_linha,
   input  logic [END_W-1:0]   end_coluna,
   input  logic               req_leitura,
   output logic [LARGURA-1:0] saida,
   output logic               saida_valida,
   output logic               erro_end,
   input  logic               carga_inicio,
   input  logic [LARGURA-1:0] carga_dado,
   input  logic               carga_valido,
   input  logic               carga_fim,
   output logic               carga_pronto,
   output logic               erro_carga,
   output logic               ocupado
);

   localparam int LIN_W = (LINHAS > 1) ? $clog2(LINHAS) : 1;
   localparam int COL_W = (COLUNAS > 1) ? $clog2(COLUNAS) : 1;
   localparam int PROF  = LINHAS * COLUNAS;
   localparam int IDX_W = (PROF > 1) ? $clog2(PROF) : 1;

   typedef enum logic [1:0] {LIMPA, OCIOSO, CARGA} estado_t;

   estado_t            estado_q, estado_d;
   logic [LIN_W-1:0]   lin_q, lin_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic               erro_carga_q, erro_carga_d;
   logic [LARGURA-1:0] saida_q;
   logic               valida_q, erro_end_q;

   logic [LARGURA-1:0] mem [PROF];
   logic               wr_en;
   logic [LARGURA-1:0] wr_dado;
   logic [IDX_W-1:0]   wr_idx, rd_idx;
   logic               ult_col, ult_cel, rd_fora;
   logic [LIN_W-1:0]   prox_lin;
   logic [COL_W-1:0]   prox_col;

   // Row-major pointer walk shared by the clear sweep and the load stream.
   assign ult_col  = (col_q == COL_W'(COLUNAS - 1));
   assign ult_cel  = ult_col && (lin_q == LIN_W'(LINHAS - 1));
   assign prox_col = ult_col ? '0 : col_q + 1'b1;
   assign prox_lin = ult_col ? lin_q + 1'b1 : lin_q;
   assign wr_idx   = IDX_W'(lin_q) * IDX_W'(COLUNAS) + IDX_W'(col_q);

   // Full-width compare so high address bits are never silently dropped.
   assign rd_fora = (32'(end_linha) >= 32'(LINHAS)) || (32'(end_coluna) >= 32'(COLUNAS));
   assign rd_idx  = rd_fora ? '0
                            : IDX_W'(LIN_W'(end_linha)) * IDX_W'(COLUNAS) + IDX_W'(COL_W'(end_coluna));

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      estado_d     = estado_q;
      lin_d        = lin_q;
      col_d        = col_q;
      erro_carga_d = erro_carga_q;
      wr_en        = 1'b0;
      wr_dado      = PALAVRA_NOP;
      unique case (estado_q)
         LIMPA: begin
            wr_en = 1'b1;
            if (ult_cel) begin
               estado_d = OCIOSO;
               lin_d    = '0;
               col_d    = '0;
            end else begin
               lin_d = prox_lin;
               col_d = prox_col;
            end
         end
         OCIOSO: begin
            if (carga_inicio) begin
               estado_d     = CARGA;
               lin_d        = '0;
               col_d        = '0;
               erro_carga_d = 1'b0;
            end
         end
         CARGA: begin
            if (carga_valido) begin
               wr_en   = 1'b1;
               wr_dado = carga_dado;
               if (!ult_cel) begin
                  lin_d = prox_lin;
                  col_d = prox_col;
               end
               if (carga_fim) begin
                  estado_d = OCIOSO;
               end else if (ult_cel) begin
                  estado_d     = OCIOSO;
                  erro_carga_d = 1'b1;
               end
            end
         end
         default: estado_d = LIMPA;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado_q     <= LIMPA;
         lin_q        <= '0;
         col_q        <= '0;
         erro_carga_q <= 1'b0;
         saida_q      <= PALAVRA_NOP;
         valida_q     <= 1'b0;
         erro_end_q   <= 1'b0;
      end else begin
         estado_q     <= estado_d;
         lin_q        <= lin_d;
         col_q        <= col_d;
         erro_carga_q <= erro_carga_d;
         if ((estado_q == OCIOSO) && req_leitura) begin
            valida_q   <= 1'b1;
            erro_end_q <= rd_fora;
            saida_q    <= rd_fora ? PALAVRA_NOP : mem[rd_idx];
         end else begin
            valida_q   <= 1'b0;
            erro_end_q <= 1'b0;
         end
      end
   end

   // NOTE: the array has no reset; the LIMPA sweep initialises it, keeping it mappable to RAM.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_dado;
      end
   end

   assign saida        = saida_q;
   assign saida_valida = valida_q;
   assign erro_end     = erro_end_q;
   assign erro_carga   = erro_carga_q;
   assign carga_pronto = (estado_q == CARGA);
   assign ocupado      = (estado_q != OCIOSO);

endmodule

// File: tb/tb_memoria_instrucoes_carga.sv
// Bench for memoria_instrucoes_carga on a 4x4 array: flat-array reference model
// checked every cycle, plus directed literal checks that pin the model.
module tb_memoria_instrucoes_carga;

   localparam int          L   = 4;
   localparam int          C   = 4;
   localparam int          N   = L * C;
   localparam logic [31:0] NOP = 32'hD000_0000;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [10:0] end_linha, end_coluna;
   logic        req_leitura;
   logic [31:0] saida;
   logic        saida_valida, erro_end;
   logic        carga_inicio;
   logic [31:0] carga_dado;
   logic        carga_valido, carga_fim;
   logic        carga_pronto, erro_carga, ocupado;

   int total = 0;
   int bad   = 0;

   memoria_instrucoes_carga #(
      .LARGURA(32), .LINHAS(L), .COLUNAS(C), .END_W(11), .PALAVRA_NOP(NOP)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .end_linha(end_linha), .end_coluna(end_coluna), .req_leitura(req_leitura),
      .saida(saida), .saida_valida(saida_valida), .erro_end(erro_end),
      .carga_inicio(carga_inicio), .carga_dado(carga_dado),
      .carga_valido(carga_valido), .carga_fim(carga_fim),
      .carga_pronto(carga_pronto), .erro_carga(erro_carga), .ocupado(ocupado)
   );

   always #5 clock = ~clock;

   task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
      total++;
      if (atual !== esperado) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nome, atual, esperado, $time);
      end
   endtask

   // Reference model: a clear countdown, a load flag, a flat write index.
   logic [31:0] mm [N];
   int          m_limpa, m_k;
   bit          m_carga, m_err, m_val, m_eend;
   logic [31:0] m_saida;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_limpa <= N;
         m_k     <= 0;
         m_carga <= 1'b0;
         m_err   <= 1'b0;
         m_val   <= 1'b0;
         m_eend  <= 1'b0;
         m_saida <= NOP;
      end else begin
         m_val  <= 1'b0;
         m_eend <= 1'b0;
         if (m_limpa > 0) begin
            mm[N - m_limpa] <= NOP;
            m_limpa <= m_limpa - 1;
         end else if (m_carga) begin
            if (carga_valido) begin
               mm[m_k] <= carga_dado;
               m_k     <= m_k + 1;
               if (carga_fim) m_carga <= 1'b0;
               else if (m_k == N - 1) begin
                  m_err   <= 1'b1;
                  m_carga <= 1'b0;
               end
            end
         end else begin
            if (req_leitura) begin
               m_val <= 1'b1;
               if (int'(end_linha) >= L || int'(end_coluna) >= C) begin
                  m_eend  <= 1'b1;
                  m_saida <= NOP;
               end else begin
                  m_saida <= mm[int'(end_linha) * C + int'(end_coluna)];
               end
            end
            if (carga_inicio) begin
               m_carga <= 1'b1;
               m_k     <= 0;
               m_err   <= 1'b0;
            end
         end
      end
   end

   always @(negedge clock) begin
      check("ocupado", 32'(ocupado), 32'((m_limpa > 0) || m_carga));
      check("carga_pronto", 32'(carga_pronto), 32'(m_carga));
      check("erro_carga", 32'(erro_carga), 32'(m_err));
      check("saida_valida", 32'(saida_valida), 32'(m_val));
      check("erro_end", 32'(erro_end), 32'(m_eend));
      check("saida", saida, m_saida);
   end

   task automatic esperar_limpa(output int n);
      n = 0;
      while (ocupado && n < 100) begin
         @(negedge clock);
         n++;
      end
   endtask

   task automatic ler(input int l, input int c, output logic [31:0] d, output logic e, output logic v);
      end_linha   = 11'(l);
      end_coluna  = 11'(c);
      req_leitura = 1'b1;
      @(negedge clock);
      req_leitura = 1'b0;
      d = saida;
      e = erro_end;
      v = saida_valida;
   endtask

   task automatic beat(input logic [31:0] dado, input logic fim);
      carga_valido = 1'b1;
      carga_dado   = dado;
      carga_fim    = fim;
      @(negedge clock);
      carga_valido = 1'b0;
      carga_fim    = 1'b0;
   endtask

   task automatic iniciar_carga();
      carga_inicio = 1'b1;
      @(negedge clock);
      carga_inicio = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      logic        e, v;
      int          n;
      reset_n      = 1'b0;
      end_linha    = '0;
      end_coluna   = '0;
      req_leitura  = 1'b0;
      carga_inicio = 1'b0;
      carga_dado   = '0;
      carga_valido = 1'b0;
      carga_fim    = 1'b0;
      repeat (2) @(negedge clock);
      check("rst_ocupado", 32'(ocupado), 32'd1);
      check("rst_saida", saida, NOP);

      // 1: clear sweep length, then a read of a cleared cell
      reset_n = 1'b1;
      esperar_limpa(n);
      check("t1_limpa_ciclos", 32'(n), 32'd16);
      ler(2, 3, d, e, v);
      check("t1_valida", 32'(v), 32'd1);
      check("t1_dado", d, 32'hD000_0000);

      // 2: five beats with a two-cycle stall
      iniciar_carga();
      beat(32'h11, 1'b0);
      beat(32'h22, 1'b0);
      beat(32'h33, 1'b0);
      repeat (2) @(negedge clock);
      beat(32'h44, 1'b0);
      beat(32'h55, 1'b1);
      check("t2_pronto", 32'(carga_pronto), 32'd0);
      ler(0, 0, d, e, v); check("t2_00", d, 32'h11);
      ler(0, 3, d, e, v); check("t2_03", d, 32'h44);
      ler(1, 0, d, e, v); check("t2_10", d, 32'h55);
      ler(1, 1, d, e, v); check("t2_11", d, 32'hD000_0000);
      check("t2_erro_carga", 32'(erro_carga), 32'd0);

      // 3: overflow on the 16th beat; the 17th is refused
      iniciar_carga();
      for (int i = 1; i <= 16; i++) beat(32'h100 + 32'(i), 1'b0);
      check("t3_erro_carga", 32'(erro_carga), 32'd1);
      check("t3_ocupado", 32'(ocupado), 32'd0);
      beat(32'h111, 1'b0);
      ler(0, 0, d, e, v); check("t3_00", d, 32'h101);
      ler(3, 3, d, e, v); check("t3_33", d, 32'h110);
      iniciar_carga();
      check("t3_erro_limpo", 32'(erro_carga), 32'd0);
      beat(32'hABC, 1'b1);

      // 4: out-of-range addresses, then a valid corner
      ler(4, 0, d, e, v);
      check("t4_40_dado", d, 32'hD000_0000);
      check("t4_40_erro", 32'(e), 32'd1);
      ler(0, 7, d, e, v);
      check("t4_07_erro", 32'(e), 32'd1);
      check("t4_07_valida", 32'(v), 32'd1);
      ler(3, 3, d, e, v);
      check("t4_33_erro", 32'(e), 32'd0);
      check("t4_33_dado", d, 32'h110);

      // 6: read and load start in the same idle cycle
      end_linha    = '0;
      end_coluna   = '0;
      req_leitura  = 1'b1;
      carga_inicio = 1'b1;
      @(negedge clock);
      req_leitura  = 1'b0;
      carga_inicio = 1'b0;
      check("t6_valida", 32'(saida_valida), 32'd1);
      check("t6_dado", saida, 32'hABC);
      check("t6_pronto", 32'(carga_pronto), 32'd1);

      // 5: reset mid-load is immediate, clear reruns, everything reads NOP
      beat(32'h201, 1'b0);
      beat(32'h202, 1'b0);
      beat(32'h203, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      check("t5_ocupado", 32'(ocupado), 32'd1);
      check("t5_pronto", 32'(carga_pronto), 32'd0);
      check("t5_saida", saida, 32'hD000_0000);
      check("t5_valida", 32'(saida_valida), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      esperar_limpa(n);
      check("t5_limpa_ciclos", 32'(n), 32'd16);
      for (int l = 0; l < L; l++) begin
         for (int c = 0; c < C; c++) begin
            ler(l, c, d, e, v);
            check("t5_celula", d, 32'hD000_0000);
         end
      end

      @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
